lc_transition_ctrl: RTL and testbench

- Parametrised lifecycle transition controller, successor to the fixed-width decoded lifecycle state enum.
- Holds the decoded lifecycle state, which is generalised to N test unlock/lock pairs.
- Validates requested transitions, runs a timed programming sequence, counts transitions, and handles escalation.
- Sits between the lifecycle request interface and the OTP programming path.

---
 rtl/lc_transition_ctrl.sv | 174 +++++++++++++++++
 tb/tb_lc_transition_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/lc_transition_ctrl.sv
// Lifecycle transition controller: validates requests, runs a timed OTP programming window,
// counts transitions and locks into ESCALATE on esc_i. Optional token gate: LC_TOKEN_CHECK_EN.
module lc_transition_ctrl #(
   parameter int NumTestStates  = 8,
   parameter int StateW         = $clog2(2*NumTestStates+8),
   parameter int MaxTransitions = 24,
   parameter int CntW           = $clog2(MaxTransitions+1),
   parameter int ProgCycles     = 4
`ifdef LC_TOKEN_CHECK_EN
  ,parameter int                TokenW      = 32,
   parameter logic [TokenW-1:0] UnlockToken = TokenW'(32'hA5C3_0F96)
`endif
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              init_valid_i,
   input  logic [StateW-1:0] init_state_i,
   input  logic [CntW-1:0]   init_cnt_i,
   input  logic              req_i,
   input  logic [StateW-1:0] target_i,
   input  logic              esc_i,
`ifdef LC_TOKEN_CHECK_EN
   input  logic [TokenW-1:0] token_i,
`endif
   output logic              ack_o,
   output logic [1:0]        err_o,
   output logic              busy_o,
   output logic [StateW-1:0] dec_state_o,
   output logic [CntW-1:0]   trans_cnt_o
);

   localparam int N2 = 2*NumTestStates;
   localparam logic [StateW-1:0] StEscalate = StateW'(N2+6);
   localparam logic [StateW-1:0] StInvalid  = StateW'(N2+7);
   localparam int PW = (ProgCycles > 1) ? $clog2(ProgCycles) : 1;
   localparam logic [PW-1:0] ProgLast = PW'(ProgCycles-1);
   localparam logic [1:0] ErrOk  = 2'd0;
   localparam logic [1:0] ErrInv = 2'd1;
   localparam logic [1:0] ErrCnt = 2'd2;
`ifdef LC_TOKEN_CHECK_EN
   localparam logic [1:0] ErrTok = 2'd3;
`endif

   typedef enum logic [2:0] {IDLE, CHECK, PROGRAM, DONE, ERROR, ESCALATE} state_t;

   state_t            r_state, w_stateNext;
   logic [StateW-1:0] r_dec, w_decNext;
   logic [CntW-1:0]   r_cnt, w_cntNext;
   logic [StateW-1:0] r_tgt, w_tgtNext;
   logic [PW-1:0]     r_prog, w_progNext;
   logic              r_ack, w_ackNext;
   logic [1:0]        r_err, w_errNext;
   logic [1:0]        w_verdict;
`ifdef LC_TOKEN_CHECK_EN
   logic [TokenW-1:0] r_token;
`endif

   // Transition legality, checked in priority order: count limit, dead/illegal states, then the graph.
   function automatic logic [1:0] verdict(input logic [StateW-1:0] cur, input logic [StateW-1:0] tgt,
                                          input logic [CntW-1:0] cnt);
      int c;
      int t;
      c = int'(cur);
      t = int'(tgt);
      if (int'(cnt) >= MaxTransitions) return ErrCnt;
      if (c >= N2+4 || t >= N2+5 || t == c) return ErrInv;
      if (t == N2+4) return ErrOk;
      if (t == N2+3) return ((c < N2 && cur[0]) || c == N2 || c == N2+1) ? ErrOk : ErrInv;
      if (t >= N2 && t <= N2+2) return (c >= 1 && c < N2) ? ErrOk : ErrInv;
      if (t >= 1 && t < N2) return (c < N2 && t > c && (tgt[0] != cur[0])) ? ErrOk : ErrInv;
      return ErrInv;
   endfunction

   always_comb begin
      w_verdict = verdict(r_dec, r_tgt, r_cnt);
`ifdef LC_TOKEN_CHECK_EN
      if (w_verdict == ErrOk && r_tgt[0] && int'(r_tgt) < N2 && r_token != UnlockToken)
         w_verdict = ErrTok;
`endif
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
         r_dec   <= StInvalid;
         r_cnt   <= '0;
         r_tgt   <= '0;
         r_prog  <= '0;
         r_ack   <= 1'b0;
         r_err   <= 2'd0;
      end else begin
         r_state <= w_stateNext;
         r_dec   <= w_decNext;
         r_cnt   <= w_cntNext;
         r_tgt   <= w_tgtNext;
         r_prog  <= w_progNext;
         r_ack   <= w_ackNext;
         r_err   <= w_errNext;
      end
   end

`ifdef LC_TOKEN_CHECK_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_token <= '0;
      else if (r_state == IDLE && !init_valid_i && req_i && !esc_i) r_token <= token_i;
   end
`endif

   // Escalation overrides everything; once in ESCALATE only requests are answered (always with an error).
   always_comb begin
      w_stateNext = r_state;
      w_decNext   = r_dec;
      w_cntNext   = r_cnt;
      w_tgtNext   = r_tgt;
      w_progNext  = r_prog;
      w_ackNext   = 1'b0;
      w_errNext   = ErrOk;
      if (r_state == ESCALATE) begin
         if (req_i) begin
            w_ackNext = 1'b1;
            w_errNext = ErrInv;
         end
      end else if (esc_i) begin
         w_stateNext = ESCALATE;
         w_decNext   = StEscalate;
         if (r_state == CHECK || r_state == PROGRAM) begin
            w_ackNext = 1'b1;
            w_errNext = ErrInv;
         end
      end else begin
         case (r_state)
            IDLE: begin
               if (init_valid_i) begin
                  w_decNext = init_state_i;
                  w_cntNext = init_cnt_i;
               end else if (req_i) begin
                  w_tgtNext   = target_i;
                  w_stateNext = CHECK;
               end
            end
            CHECK: begin
               if (w_verdict == ErrOk) begin
                  w_stateNext = PROGRAM;
                  w_cntNext   = r_cnt + CntW'(1);
                  w_progNext  = '0;
               end else begin
                  w_stateNext = ERROR;
                  w_ackNext   = 1'b1;
                  w_errNext   = w_verdict;
               end
            end
            PROGRAM: begin
               if (r_prog == ProgLast) begin
                  w_stateNext = DONE;
                  w_decNext   = r_tgt;
                  w_ackNext   = 1'b1;
               end else begin
                  w_progNext = r_prog + PW'(1);
               end
            end
            DONE:    w_stateNext = IDLE;
            ERROR:   w_stateNext = IDLE;
            default: w_stateNext = IDLE;
         endcase
      end
   end

   assign ack_o       = r_ack;
   assign err_o       = r_err;
   assign busy_o      = (r_state != IDLE) && (r_state != ESCALATE);
   assign dec_state_o = r_dec;
   assign trans_cnt_o = r_cnt;

endmodule

// File: tb/tb_lc_transition_ctrl.sv
// Scoreboard bench for lc_transition_ctrl (default parameters); exercises the token gate
// when LC_TOKEN_CHECK_EN is defined.
module tb_lc_transition_ctrl;

   localparam logic [31:0] GoodToken = 32'hA5C3_0F96;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       init_valid_i = 1'b0;
   logic [4:0] init_state_i = '0;
   logic [4:0] init_cnt_i = '0;
   logic       req_i = 1'b0;
   logic [4:0] target_i = '0;
   logic       esc_i = 1'b0;
   logic [31:0] tokenVal = GoodToken;
   logic       ack_o;
   logic [1:0] err_o;
   logic       busy_o;
   logic [4:0] dec_state_o;
   logic [4:0] trans_cnt_o;

   typedef struct {int err; int cnt;} exp_t;
   exp_t sbQ[$];

   int checks = 0;
   int errors = 0;

   lc_transition_ctrl dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .init_valid_i(init_valid_i), .init_state_i(init_state_i), .init_cnt_i(init_cnt_i),
      .req_i(req_i), .target_i(target_i), .esc_i(esc_i),
`ifdef LC_TOKEN_CHECK_EN
      .token_i(tokenVal),
`endif
      .ack_o(ack_o), .err_o(err_o), .busy_o(busy_o),
      .dec_state_o(dec_state_o), .trans_cnt_o(trans_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // Every comparison funnels through here so the counters stay honest.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
      end
   endtask

   // Any completion pulse must match the oldest queued expectation.
   always @(negedge clk_i) begin
      if (rst_ni && ack_o) begin
         if (sbQ.size() == 0) begin
            checkOutput("unexpectedAck", 1, 0);
         end else begin
            exp_t e;
            e = sbQ.pop_front();
            checkOutput("ackErr", int'(err_o), e.err);
            checkOutput("ackCnt", int'(trans_cnt_o), e.cnt);
         end
      end
   end

   task automatic applyInit(input int st, input int cnt);
      @(posedge clk_i); #1;
      init_valid_i = 1'b1;
      init_state_i = 5'(st);
      init_cnt_i   = 5'(cnt);
      @(posedge clk_i); #1;
      init_valid_i = 1'b0;
   endtask

   task automatic applyStimulus(input int tgt, input int expErr, input int expCnt, input bit push);
      exp_t e;
      @(posedge clk_i); #1;
      if (push) begin
         e.err = expErr;
         e.cnt = expCnt;
         sbQ.push_back(e);
      end
      req_i    = 1'b1;
      target_i = 5'(tgt);
      @(posedge clk_i); #1;
      req_i = 1'b0;
   endtask

   task automatic waitAckDone(input int budget);
      int n;
      n = 0;
      while (sbQ.size() != 0 && n < budget) begin
         @(posedge clk_i);
         n++;
      end
      if (sbQ.size() != 0) begin
         checkOutput("ackTimeout", sbQ.size(), 0);
         sbQ.delete();
      end
      @(posedge clk_i);
   endtask

   task automatic checkState(input string tag, input int st, input int cnt);
      @(negedge clk_i);
      checkOutput({tag, "State"}, int'(dec_state_o), st);
      checkOutput({tag, "Cnt"}, int'(trans_cnt_o), cnt);
   endtask

   initial begin
      repeat (2) @(negedge clk_i);
      checkOutput("rstState", int'(dec_state_o), 23);
      checkOutput("rstCnt", int'(trans_cnt_o), 0);
      checkOutput("rstAck", int'(ack_o), 0);
      checkOutput("rstErr", int'(err_o), 0);
      checkOutput("rstBusy", int'(busy_o), 0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;

      // Raw -> TestUnlocked0 with exact latency.
      applyInit(0, 0);
      applyStimulus(1, 0, 1, 1'b1);
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk_i);
         checkOutput("busyWindow", int'(busy_o), 1);
         checkOutput("noEarlyAck", int'(ack_o), 0);
      end
      @(negedge clk_i);
      checkOutput("ackAtT6", int'(ack_o), 1);
      waitAckDone(20);
      checkState("raw2tu0", 1, 1);
      checkOutput("idleBusy", int'(busy_o), 0);

      // Backwards test transition rejected, forward accepted.
      applyInit(2, 0);
      applyStimulus(1, 1, 0, 1'b1);
      waitAckDone(20);
      checkState("tl0Back", 2, 0);
      applyStimulus(3, 0, 1, 1'b1);
      waitAckDone(20);
      checkState("tl0Fwd", 3, 1);

      // A request while busy is dropped.
      applyStimulus(4, 0, 2, 1'b1);
      @(posedge clk_i); #1;
      req_i = 1'b1;
      target_i = 5'd23;
      @(posedge clk_i); #1;
      req_i = 1'b0;
      waitAckDone(20);
      repeat (3) @(posedge clk_i);
      checkState("busyReq", 4, 2);

      // Prod -> Rma -> Scrap, then Scrap is dead.
      applyInit(17, 5);
      applyStimulus(19, 0, 6, 1'b1);
      waitAckDone(20);
      checkState("prod2rma", 19, 6);
      applyStimulus(20, 0, 7, 1'b1);
      waitAckDone(20);
      checkState("rma2scrap", 20, 7);
      applyStimulus(16, 1, 7, 1'b1);
      waitAckDone(20);
      checkState("scrapDead", 20, 7);

      // Transition count limit.
      applyInit(0, 22);
      applyStimulus(1, 0, 23, 1'b1);
      waitAckDone(20);
      applyStimulus(2, 0, 24, 1'b1);
      waitAckDone(20);
      applyStimulus(3, 2, 24, 1'b1);
      waitAckDone(20);
      checkState("cntLimit", 2, 24);

      // Out-of-range target, same-parity target, self target.
      applyInit(0, 0);
      applyStimulus(25, 1, 0, 1'b1);
      waitAckDone(20);
      applyStimulus(2, 1, 0, 1'b1);
      waitAckDone(20);
      applyStimulus(0, 1, 0, 1'b1);
      waitAckDone(20);
      checkState("badTargets", 0, 0);

`ifdef LC_TOKEN_CHECK_EN
      tokenVal = 32'h1234_5678;
      applyStimulus(1, 3, 0, 1'b1);
      waitAckDone(20);
      checkState("badToken", 0, 0);
      tokenVal = GoodToken;
      applyStimulus(1, 0, 1, 1'b1);
      waitAckDone(20);
      checkState("goodToken", 1, 1);
`endif

      // Escalation during PROGRAM keeps the incremented count.
      applyInit(0, 3);
      applyStimulus(1, 1, 4, 1'b1);
      @(posedge clk_i); #1;
      esc_i = 1'b1;
      waitAckDone(20);
      checkState("escProg", 22, 4);
      checkOutput("escBusy", int'(busy_o), 0);
      applyStimulus(3, 1, 4, 1'b1);
      waitAckDone(20);
      esc_i = 1'b0;
      applyInit(0, 0);
      repeat (2) @(posedge clk_i);
      checkState("escInit", 22, 4);

      // Asynchronous reset mid-PROGRAM aborts without an ack.
      @(posedge clk_i); #1;
      rst_ni = 1'b0;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      applyInit(0, 0);
      applyStimulus(1, 0, 0, 1'b0);
      repeat (2) @(posedge clk_i);
      #3;
      rst_ni = 1'b0;
      #1;
      checkOutput("abortState", int'(dec_state_o), 23);
      checkOutput("abortCnt", int'(trans_cnt_o), 0);
      checkOutput("abortBusy", int'(busy_o), 0);
      checkOutput("abortAck", int'(ack_o), 0);
      repeat (2) @(posedge clk_i); #1;
      rst_ni = 1'b1;
      repeat (10) @(posedge clk_i);
      checkOutput("sbEmpty", sbQ.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL globalTimeout observed=1 expected=0");
      $fatal(1, "[TB] timeout");
   end

endmodule
